// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared WS2812B timing constants and GRB pixel layout
package ws2812b_pkg;

  // Line timing in clocks at 50 MHz
  localparam int WS_BIT_THRESH_CLK = 30;    // high time at/above which a bit is 1
  localparam int WS_MAX_HIGH_CLK   = 60;    // high time at/above which a pulse is malformed
  localparam int WS_LATCH_LOW_CLK  = 2500;  // low time that latches a frame
  localparam int WS_BIT_PERIOD_CLK = 63;    // nominal high+low time of one bit

  // Pixel layout: green first on the wire, MSB first
  localparam int BITS_PER_PIXEL = 24;
  localparam int GREEN_LSB      = 16;
  localparam int RED_LSB        = 8;
  localparam int BLUE_LSB       = 0;

  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } grb_t;

  function automatic grb_t unpack_grb(input logic [BITS_PER_PIXEL-1:0] word);
    grb_t p;
    p.green = word[GREEN_LSB +: 8];
    p.red   = word[RED_LSB   +: 8];
    p.blue  = word[BLUE_LSB  +: 8];
    return p;
  endfunction

endpackage

// File: rtl/ws2812b_line_decoder_bit_slicer.sv
// rtl/ws2812b_line_decoder_bit_slicer.sv - synchronizes the line and slices high pulses into bits
module ws2812b_bit_slicer #(
  parameter int BIT_THRESH_CLK = 30,
  parameter int MAX_HIGH_CLK   = 60,
  parameter int LATCH_LOW_CLK  = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic line_raw,
  output logic bit_strobe,
  output logic bit_value,
  output logic latch_strobe,
  output logic pulse_error
);

  localparam int HW = $clog2(MAX_HIGH_CLK + 1);
  localparam int LW = $clog2(LATCH_LOW_CLK + 1);

  localparam logic [HW-1:0] HIGH_ONE   = HW'(BIT_THRESH_CLK);
  localparam logic [HW-1:0] HIGH_LIMIT = HW'(MAX_HIGH_CLK - 1);
  localparam logic [LW-1:0] LOW_LAST   = LW'(LATCH_LOW_CLK - 1);
  localparam logic [LW-1:0] LOW_SAT    = LW'(LATCH_LOW_CLK);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic [1:0]    state;
  logic          line_meta;
  logic          line_s;
  logic          line_q;
  logic          rise;
  logic          fall;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;

  assign rise = line_s & ~line_q;
  assign fall = ~line_s & line_q;

  // Two-flop synchronizer followed by the edge-detect register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_meta <= 1'b0;
      line_s    <= 1'b0;
      line_q    <= 1'b0;
    end else begin
      line_meta <= line_raw;
      line_s    <= line_meta;
      line_q    <= line_s;
    end
  end

  // SYNC/IDLE/HIGH state machine timing the synchronized line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_SYNC;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_strobe   <= 1'b0;
      bit_value    <= 1'b0;
      latch_strobe <= 1'b0;
      pulse_error  <= 1'b0;
    end else begin
      bit_strobe   <= 1'b0;
      latch_strobe <= 1'b0;
      pulse_error  <= 1'b0;
      case (state)
        ST_SYNC: begin
          // Wait for one full latch gap so we never lock on mid-frame
          if (line_s) begin
            low_cnt <= '0;
          end else begin
            low_cnt <= low_cnt + 1'b1;
            if (low_cnt == LOW_LAST) state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            state    <= ST_HIGH;
            high_cnt <= HW'(1);
            low_cnt  <= '0;
          end else if (low_cnt != LOW_SAT) begin
            low_cnt <= low_cnt + 1'b1;
            if (low_cnt == LOW_LAST) latch_strobe <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            bit_strobe <= 1'b1;
            bit_value  <= (high_cnt >= HIGH_ONE);
            state      <= ST_IDLE;
            low_cnt    <= LW'(1);
          end else if (high_cnt == HIGH_LIMIT) begin
            // Line still high as the count reaches the limit: malformed pulse
            pulse_error <= 1'b1;
            state       <= ST_SYNC;
            low_cnt     <= '0;
          end else begin
            high_cnt <= high_cnt + 1'b1;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: rtl/ws2812b_line_decoder.sv
// rtl/ws2812b_line_decoder.sv - assembles sliced WS2812B bits into GRB pixels and frames
module ws2812b_line_decoder
  import ws2812b_pkg::*;
#(
  parameter int MAX_POS        = 109,
  parameter int BIT_THRESH_CLK = WS_BIT_THRESH_CLK,
  parameter int MAX_HIGH_CLK   = WS_MAX_HIGH_CLK,
  parameter int LATCH_LOW_CLK  = WS_LATCH_LOW_CLK
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       leds_line,
  output logic                       pixel_valid,
  output logic [$clog2(MAX_POS)-1:0] pixel_index,
  output logic [7:0]                 pixel_green,
  output logic [7:0]                 pixel_red,
  output logic [7:0]                 pixel_blue,
  output logic                       frame_done,
  output logic [$clog2(MAX_POS):0]   frame_pixels,
  output logic                       err_pulse,
  output logic                       err_partial,
  output logic                       err_overflow
);

  localparam int IW = $clog2(MAX_POS);
  localparam int CW = IW + 1;

  localparam logic [CW-1:0] POS_LIMIT = CW'(MAX_POS);
  localparam logic [4:0]    LAST_BIT  = 5'(BITS_PER_PIXEL - 1);

  logic                      bit_strobe;
  logic                      bit_value;
  logic                      latch_strobe;
  logic                      pulse_error;
  // Only the 23 earlier bits are stored; the 24th arrives with bit_strobe
  logic [BITS_PER_PIXEL-2:0] shift_q;
  logic [BITS_PER_PIXEL-1:0] shift_next;
  grb_t                      next_pix;
  logic [4:0]                bit_cnt;
  logic [CW-1:0]             pix_cnt;
  logic                      frame_active;

  ws2812b_bit_slicer #(
    .BIT_THRESH_CLK(BIT_THRESH_CLK),
    .MAX_HIGH_CLK  (MAX_HIGH_CLK),
    .LATCH_LOW_CLK (LATCH_LOW_CLK)
  ) u_slicer (
    .clk         (clk),
    .reset       (reset),
    .line_raw    (leds_line),
    .bit_strobe  (bit_strobe),
    .bit_value   (bit_value),
    .latch_strobe(latch_strobe),
    .pulse_error (pulse_error)
  );

  assign shift_next = {shift_q, bit_value};
  assign next_pix   = unpack_grb(shift_next);

  // Bit assembly, pixel counting, latch handling and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      frame_active <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      pixel_green  <= '0;
      pixel_red    <= '0;
      pixel_blue   <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err_pulse    <= 1'b0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      err_pulse    <= 1'b0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      if (pulse_error) begin
        // Drop the half-built pixel but keep the frame's pixel count
        err_pulse <= 1'b1;
        bit_cnt   <= '0;
      end else if (bit_strobe) begin
        shift_q      <= shift_next[BITS_PER_PIXEL-2:0];
        frame_active <= 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (pix_cnt < POS_LIMIT) begin
            pixel_valid <= 1'b1;
            pixel_index <= pix_cnt[IW-1:0];
            pixel_green <= next_pix.green;
            pixel_red   <= next_pix.red;
            pixel_blue  <= next_pix.blue;
            pix_cnt     <= pix_cnt + 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (latch_strobe && frame_active) begin
        frame_done   <= 1'b1;
        frame_pixels <= pix_cnt;
        err_partial  <= (bit_cnt != '0);
        pix_cnt      <= '0;
        bit_cnt      <= '0;
        frame_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812b_line_decoder.sv
// tb/tb_ws2812b_line_decoder.sv - self-checking bench for ws2812b_line_decoder
module tb_ws2812b_line_decoder;
  import ws2812b_pkg::*;

  localparam int MAX_POS    = 109;
  localparam int IW         = $clog2(MAX_POS);
  localparam int LATCH_WAIT = 2560;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          leds_line = 1'b0;
  logic          pixel_valid;
  logic [IW-1:0] pixel_index;
  logic [7:0]    pixel_green;
  logic [7:0]    pixel_red;
  logic [7:0]    pixel_blue;
  logic          frame_done;
  logic [IW:0]   frame_pixels;
  logic          err_pulse;
  logic          err_partial;
  logic          err_overflow;

  ws2812b_line_decoder #(.MAX_POS(MAX_POS)) dut (
    .clk         (clk),
    .reset       (reset),
    .leds_line   (leds_line),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .pixel_green (pixel_green),
    .pixel_red   (pixel_red),
    .pixel_blue  (pixel_blue),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .err_pulse   (err_pulse),
    .err_partial (err_partial),
    .err_overflow(err_overflow)
  );

  always #10 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  longint fall_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [23:0] grb;
    longint      at;
  } pix_obs_t;

  typedef struct {
    int high;
    int exp_bit;
    bit exp_err;
  } bit_vec_t;

  pix_obs_t    obs_pix[$];
  int          obs_fp[$];
  bit          obs_part[$];
  int          n_perr  = 0;
  int          n_ovf   = 0;
  int          n_stray = 0;
  logic [23:0] sent_q[$];
  bit_vec_t    bit_tab[6];

  // Monitor: records every strobe seen on the outputs
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_valid)
        obs_pix.push_back('{idx: int'(pixel_index), grb: {pixel_green, pixel_red, pixel_blue}, at: cyc});
      if (frame_done) begin
        obs_fp.push_back(int'(frame_pixels));
        obs_part.push_back(err_partial);
      end else if (err_partial) begin
        n_stray++;
      end
      if (err_pulse) n_perr++;
      if (err_overflow) n_ovf++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_raw(input int high, input int low);
    leds_line = 1'b1;
    repeat (high) @(negedge clk);
    leds_line = 1'b0;
    fall_cyc = cyc;
    repeat (low) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input bit fast);
    int high;
    if (fast) begin
      send_raw(b ? 30 : 2, 2);
    end else begin
      high = b ? int'($urandom_range(32, 55)) : int'($urandom_range(8, 26));
      send_raw(high, WS_BIT_PERIOD_CLK - high);
    end
  endtask

  task automatic send_pixel(input logic [23:0] v, input bit fast, input bit expect_it);
    for (int i = 23; i >= 0; i--) send_bit(v[i], fast);
    if (expect_it) sent_q.push_back(v);
  endtask

  task automatic latch();
    repeat (LATCH_WAIT) @(negedge clk);
  endtask

  // Expected results follow from the list of pixels sent: the first MAX_POS
  // are reported in order, the rest overflow, and one latch reports the total.
  task automatic check_frame(input string name, input int exp_frames, input bit exp_partial,
                             input int exp_perr);
    int n;
    int np;
    n  = sent_q.size();
    np = (n < MAX_POS) ? n : MAX_POS;
    check($sformatf("%s pixel count", name), obs_pix.size(), np);
    for (int i = 0; i < np && i < obs_pix.size(); i++)
      check($sformatf("%s pixel %0d", name, i),
            {32'(obs_pix[i].idx), 8'h00, obs_pix[i].grb}, {32'(i), 8'h00, sent_q[i]});
    check($sformatf("%s frame_done count", name), obs_fp.size(), exp_frames);
    if (obs_fp.size() > 0) begin
      check($sformatf("%s frame_pixels", name), obs_fp[0], np);
      check($sformatf("%s err_partial", name), obs_part[0], exp_partial);
    end
    check($sformatf("%s err_overflow count", name), n_ovf, n - np);
    check($sformatf("%s err_pulse count", name), n_perr, exp_perr);
    check($sformatf("%s stray err_partial", name), n_stray, 0);
    obs_pix.delete();
    obs_fp.delete();
    obs_part.delete();
    sent_q.delete();
    n_perr  = 0;
    n_ovf   = 0;
    n_stray = 0;
  endtask

  initial begin
    #(3_000_000 * 20);
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    longint last_fall;
    logic [22:0] rest;
    logic [23:0] v;
    int n;
    int extra;

    bit_tab[0] = '{high: 1,  exp_bit: 0, exp_err: 1'b0};
    bit_tab[1] = '{high: 15, exp_bit: 0, exp_err: 1'b0};
    bit_tab[2] = '{high: 29, exp_bit: 0, exp_err: 1'b0};
    bit_tab[3] = '{high: 30, exp_bit: 1, exp_err: 1'b0};
    bit_tab[4] = '{high: 59, exp_bit: 1, exp_err: 1'b0};
    bit_tab[5] = '{high: 60, exp_bit: 0, exp_err: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs",
          {pixel_valid, pixel_index, pixel_green, pixel_red, pixel_blue,
           frame_done, frame_pixels, err_pulse, err_partial, err_overflow}, 64'd0);
    reset = 1'b0;
    latch();
    check("quiet after reset", obs_pix.size() + obs_fp.size() + n_perr + n_ovf + n_stray, 0);

    // Single pixel with exact output latency
    send_pixel(24'hFF000F, 1'b0, 1'b1);
    last_fall = fall_cyc;
    latch();
    if (obs_pix.size() > 0) check("pixel latency", obs_pix[0].at - last_fall, 4);
    check_frame("single", 1, 1'b0, 0);

    // Three pixels
    send_pixel(24'h123456, 1'b1, 1'b1);
    send_pixel(24'hABCDEF, 1'b1, 1'b1);
    send_pixel(24'h000001, 1'b1, 1'b1);
    latch();
    check_frame("three", 1, 1'b0, 0);

    // Bit-timing table: first bit's high time is the one under test
    for (int t = 0; t < 6; t++) begin
      rest = 23'($urandom);
      send_raw(bit_tab[t].high, 20);
      if (!bit_tab[t].exp_err) begin
        for (int i = 22; i >= 0; i--) send_bit(rest[i], 1'b1);
        sent_q.push_back({1'(bit_tab[t].exp_bit), rest});
        latch();
        check_frame($sformatf("high %0d", bit_tab[t].high), 1, 1'b0, 0);
      end else begin
        // Decoder must now ignore the line until a full latch gap
        repeat (100) @(negedge clk);
        send_pixel({1'b1, rest}, 1'b1, 1'b0);
        latch();
        check_frame($sformatf("high %0d", bit_tab[t].high), 0, 1'b0, 1);
      end
    end

    // Reset released while the line is toggling
    reset = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 43; i++) send_bit(1'($urandom), 1'b1);
    latch();
    check_frame("reset mid-frame", 0, 1'b0, 0);
    send_pixel(24'(($urandom)), 1'b0, 1'b1);
    latch();
    check_frame("after reset", 1, 1'b0, 0);

    // Partial pixel at latch, then a clean frame
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b1);
    latch();
    check_frame("partial", 1, 1'b1, 0);
    send_pixel(24'($urandom), 1'b1, 1'b1);
    latch();
    check_frame("after partial", 1, 1'b0, 0);

    // Randomized frames with jittered bit timing
    for (int f = 0; f < 3; f++) begin
      n     = int'($urandom_range(1, 2));
      extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 23)) : 0;
      for (int p = 0; p < n; p++) send_pixel(24'($urandom), 1'b0, 1'b1);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom), 1'b0);
      latch();
      check_frame($sformatf("random frame %0d", f), 1, extra != 0, 0);
    end

    // One pixel more than the frame can hold
    for (int p = 0; p < MAX_POS + 1; p++) begin
      v = {8'(p), 16'h0000};
      send_pixel(v, 1'b1, 1'b1);
    end
    latch();
    check_frame("overflow", 1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
